// File: rtl/konami_pkg.sv
// Shared symbol encodings and the expected Konami sequence for the detector.
package konami_pkg;

    typedef enum logic [2:0] {
        SYM_IDLE  = 3'd0,
        SYM_UP    = 3'd1,
        SYM_DOWN  = 3'd2,
        SYM_LEFT  = 3'd3,
        SYM_RIGHT = 3'd4,
        SYM_B     = 3'd5,
        SYM_A     = 3'd6,
        SYM_START = 3'd7
    } sym_t;

    // INVALID lives on its own bit so it can never alias a real symbol internally,
    // yet it leaves the block as symbol code 0.
    typedef struct packed {
        logic invalid;
        sym_t sym;
    } cls_t;

    localparam cls_t CLS_IDLE    = '{invalid: 1'b0, sym: SYM_IDLE};
    localparam cls_t CLS_INVALID = '{invalid: 1'b1, sym: SYM_IDLE};

    localparam int unsigned SEQ_LEN  = 11;
    localparam logic [3:0]  LAST_IDX = 4'd10;

    // Element [0] is the first expected symbol.
    localparam logic [SEQ_LEN-1:0][2:0] KONAMI_SEQ = {
        SYM_START, SYM_A, SYM_B, SYM_RIGHT, SYM_LEFT, SYM_RIGHT,
        SYM_LEFT, SYM_DOWN, SYM_DOWN, SYM_UP, SYM_UP
    };

    function automatic sym_t expected_sym(input logic [3:0] idx);
        sym_t s;
        s = SYM_IDLE;
        if (idx <= LAST_IDX) begin
            s = sym_t'(KONAMI_SEQ[idx]);
        end
        return s;
    endfunction

endpackage

// File: rtl/konami_debounce.sv
// Generic level debouncer: output follows the input once it has held one value for STABLE_CYCLES samples.
module konami_debounce #(
    parameter int unsigned     WIDTH         = 4,
    parameter int unsigned     STABLE_CYCLES = 60000,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] stable_o
);
    localparam int unsigned    CNT_MAX = (STABLE_CYCLES > 0) ? STABLE_CYCLES - 1 : 0;
    localparam int unsigned    CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);

    logic [WIDTH-1:0] last_q;
    logic [WIDTH-1:0] stable_q;
    logic [CNT_W-1:0] cnt_q;

    // cnt_q == CNT_TOP means last_q has been sampled STABLE_CYCLES times in a row.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            last_q   <= RESET_VALUE;
            stable_q <= RESET_VALUE;
            cnt_q    <= '0;
        end else begin
            last_q <= raw_i;
            if (raw_i != last_q) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_TOP) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (cnt_q == CNT_TOP) begin
                stable_q <= last_q;
            end
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/konami_detector.sv
// Konami code detector: classifies joystick/buttons, debounces, emits symbols on release
// and matches them against the UP UP DOWN DOWN LEFT RIGHT LEFT RIGHT B A START sequence.
module konami_detector
    import konami_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 60000,
    parameter int unsigned LOW_THRESH      = 384,
    parameter int unsigned HIGH_THRESH     = 640
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic [9:0] position_x_i,
    input  logic [9:0] position_y_i,
    input  logic [3:1] button_async_i,
    output logic       symbol_valid_o,
    output logic [2:0] symbol_o,
    output logic [3:0] progress_o,
    output logic       unlock_o
);
    localparam logic [9:0] LOW_T  = 10'(LOW_THRESH);
    localparam logic [9:0] HIGH_T = 10'(HIGH_THRESH);

    logic [3:1] btn_meta_q;
    logic [3:1] btn_sync_q;
    logic [6:0] active;
    cls_t       raw_cls;
    cls_t       deb_cls;
    cls_t       deb_prev_q;
    cls_t       held_q;
    cls_t       held_d;
    cls_t       emit_cls_q;
    logic       emit;
    logic       valid_q;
    logic [2:0] sym_q;
    logic [3:0] idx_q;
    logic [3:0] idx_d;
    logic       unlock_q;
    logic       unlock_d;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
        end else begin
            btn_meta_q <= button_async_i;
            btn_sync_q <= btn_meta_q;
        end
    end

    // Bit order: {START, A, B, RIGHT, LEFT, DOWN, UP}
    always_comb begin
        active = {btn_sync_q[2], btn_sync_q[1], btn_sync_q[3],
                  position_x_i > HIGH_T, position_x_i < LOW_T,
                  position_y_i < LOW_T, position_y_i > HIGH_T};
        raw_cls = CLS_IDLE;
        if ($countones(active) > 1) begin
            raw_cls = CLS_INVALID;
        end else if (active[0]) begin
            raw_cls.sym = SYM_UP;
        end else if (active[1]) begin
            raw_cls.sym = SYM_DOWN;
        end else if (active[2]) begin
            raw_cls.sym = SYM_LEFT;
        end else if (active[3]) begin
            raw_cls.sym = SYM_RIGHT;
        end else if (active[4]) begin
            raw_cls.sym = SYM_B;
        end else if (active[5]) begin
            raw_cls.sym = SYM_A;
        end else if (active[6]) begin
            raw_cls.sym = SYM_START;
        end
    end

    konami_debounce #(
        .WIDTH        (4),
        .STABLE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_VALUE  (CLS_IDLE)
    ) u_debounce (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .raw_i    (raw_cls),
        .stable_o (deb_cls)
    );

    // Release emits whatever was held; a direct non-IDLE to non-IDLE move poisons the hold.
    always_comb begin
        held_d = held_q;
        emit   = 1'b0;
        if (deb_cls != deb_prev_q) begin
            if (deb_cls == CLS_IDLE) begin
                emit = 1'b1;
            end else if (deb_prev_q == CLS_IDLE) begin
                held_d = deb_cls;
            end else begin
                held_d = CLS_INVALID;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            deb_prev_q <= CLS_IDLE;
            held_q     <= CLS_IDLE;
            emit_cls_q <= CLS_IDLE;
            valid_q    <= 1'b0;
            sym_q      <= SYM_IDLE;
        end else begin
            deb_prev_q <= deb_cls;
            held_q     <= held_d;
            valid_q    <= emit;
            if (emit) begin
                emit_cls_q <= held_q;
                sym_q      <= held_q.invalid ? SYM_IDLE : held_q.sym;
            end
        end
    end

    // A mismatching UP can still be the start of a fresh attempt (or its second UP).
    always_comb begin
        idx_d    = idx_q;
        unlock_d = 1'b0;
        if (valid_q) begin
            if (!emit_cls_q.invalid && emit_cls_q.sym == expected_sym(idx_q)) begin
                if (idx_q == LAST_IDX) begin
                    idx_d    = '0;
                    unlock_d = 1'b1;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end else if (!emit_cls_q.invalid && emit_cls_q.sym == SYM_UP) begin
                idx_d = (idx_q == 4'd2) ? 4'd2 : 4'd1;
            end else begin
                idx_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            idx_q    <= '0;
            unlock_q <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            unlock_q <= unlock_d;
        end
    end

    assign symbol_valid_o = valid_q;
    assign symbol_o       = sym_q;
    assign progress_o     = idx_q;
    assign unlock_o       = unlock_q;

endmodule
